// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int PRIO_ROUND_ROBIN = 0;
    localparam int PRIO_FIXED       = 1;

    // Rejects misaligned words and any word that would run past the end of memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Two-way winner select, purely combinational (0 cycles); a lone requester always wins.
// On a tie, round-robin picks the port other than last_grant; fixed mode picks port 0.
module rr_arbiter_2
    import data_memory_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = PORT0;
        if (req == 2'b10) begin
            winner = PORT1;
        end else if (req == 2'b11) begin
            winner = (PRIORITY_MODE == PRIO_FIXED) ? PORT0 : ~last_grant;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between two requesters as 3-cycle transactions.
// Ack pulses 2 cycles after the request is taken; requesters hold req until ack.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int MEM_BYTES     = 1024,
    parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    state_t      state;
    logic        last_grant;
    logic        winner;
    logic        txn_port;
    logic        txn_err;
    logic [1:0]  ack_q;
    logic [1:0]  err_q;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    rr_arbiter_2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        sel_we    = (winner == PORT1) ? p1_we    : p0_we;
        sel_addr  = (winner == PORT1) ? p1_addr  : p0_addr;
        sel_wdata = (winner == PORT1) ? p1_wdata : p0_wdata;
        sel_err   = addr_bad(sel_addr, MEM_BYTES);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            last_grant     <= PORT1;
            txn_port       <= PORT0;
            txn_err        <= 1'b0;
            ack_q          <= 2'b00;
            err_q          <= 2'b00;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        txn_port       <= winner;
                        txn_err        <= sel_err;
                        mem_address    <= {sel_addr[31:2], 2'b00};
                        mem_write_data <= sel_wdata;
                        mem_read       <= !sel_err && !sel_we;
                        mem_write      <= !sel_err &&  sel_we;
                        state          <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // mem_read is only ever high for an error-free read.
                    if (mem_read) begin
                        if (txn_port == PORT1) p1_rdata <= mem_read_data;
                        else                   p0_rdata <= mem_read_data;
                    end
                    mem_read        <= 1'b0;
                    mem_write       <= 1'b0;
                    ack_q[txn_port] <= 1'b1;
                    err_q[txn_port] <= txn_err;
                    state           <= ST_DONE;
                end
                ST_DONE: begin
                    ack_q      <= 2'b00;
                    err_q      <= 2'b00;
                    last_grant <= txn_port;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A reset landing in DONE must swallow the ack already sitting in its register.
    assign p0_ack = ack_q[0] & ~reset;
    assign p1_ack = ack_q[1] & ~reset;
    assign p0_err = err_q[0] & ~reset;
    assign p1_err = err_q[1] & ~reset;
    assign busy   = (state != ST_IDLE);

endmodule
